// File: rtl/snn_pkg.sv
// Shared definitions for the spiking pooling datapath: spike word field offsets,
// the reserved marker channel and the pooling FSM state encoding.
package snn_pkg;

  localparam int unsigned CH_MSB  = 31;
  localparam int unsigned CH_LSB  = 24;
  localparam int unsigned ROW_MSB = 23;
  localparam int unsigned ROW_LSB = 16;
  localparam int unsigned COL_MSB = 15;
  localparam int unsigned COL_LSB = 8;
  localparam int unsigned TS_MSB  = 7;
  localparam int unsigned TS_LSB  = 0;

  // Out-of-range channel; downstream layers ignore it, so it carries timestep markers.
  localparam logic [7:0] SPIKE_MARKER_CH = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StEmit,
    StClear
  } pool_state_e;

endpackage

// File: rtl/snn_pool_bitmap.sv
// Per-timestep "already fired" bitmap: test-and-set with a registered result,
// one-channel-per-cycle clear, asynchronous clear on reset.
module snn_pool_bitmap #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MAP_BITS = 16,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned CH_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tas_en,
  input  logic [IDX_W-1:0] i_tas_idx,
  output logic             o_was_set,
  input  logic             i_clr_en,
  input  logic [CH_W-1:0]  i_clr_ch
);

  localparam int unsigned TotalBits = CHANNELS * MAP_BITS;

  logic [TotalBits-1:0] r_bits;
  logic [TotalBits-1:0] w_bits_next;
  logic                 r_was_set;

  always_comb begin
    w_bits_next = r_bits;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (i_clr_en && (i_clr_ch == CH_W'(c))) begin
        w_bits_next[c*MAP_BITS +: MAP_BITS] = '0;
      end
    end
    if (i_tas_en) begin
      w_bits_next[i_tas_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bits    <= '0;
      r_was_set <= 1'b0;
    end else begin
      r_bits <= w_bits_next;
      if (i_tas_en) begin
        r_was_set <= r_bits[i_tas_idx];
      end
    end
  end

  assign o_was_set = r_was_set;

endmodule

// File: rtl/snn_spike_pool2d.sv
// Event-driven 2D OR-pooling of AXI-Stream spike events with per-timestep dedup.
// Define SNN_POOL_STATS_EN to add drop_count / merge_count statistics ports.
module snn_spike_pool2d
  import snn_pkg::*;
#(
  parameter int unsigned INPUT_HEIGHT = 8,
  parameter int unsigned INPUT_WIDTH  = 8,
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned POOL_SIZE    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        s_axis_spike_tvalid,
  input  logic [31:0] s_axis_spike_tdata,
  input  logic        s_axis_spike_tlast,
  output logic        s_axis_spike_tready,
  output logic        m_axis_spike_tvalid,
  output logic [31:0] m_axis_spike_tdata,
  output logic        m_axis_spike_tlast,
  input  logic        m_axis_spike_tready,
  output logic [31:0] input_spike_count,
  output logic [31:0] output_spike_count,
  output logic        busy
`ifdef SNN_POOL_STATS_EN
  ,
  output logic [31:0] drop_count,
  output logic [31:0] merge_count
`endif
);

  localparam int unsigned OutHeight = INPUT_HEIGHT / POOL_SIZE;
  localparam int unsigned OutWidth  = INPUT_WIDTH / POOL_SIZE;
  localparam int unsigned MapBits   = OutHeight * OutWidth;
  localparam int unsigned TotalBits = CHANNELS * MapBits;
  localparam int unsigned IdxW      = (TotalBits > 1) ? $clog2(TotalBits) : 1;
  localparam int unsigned ChW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PoolShift = $clog2(POOL_SIZE);
  localparam int unsigned RowLimit  = OutHeight * POOL_SIZE;
  localparam int unsigned ColLimit  = OutWidth * POOL_SIZE;

  pool_state_e r_state, w_state_next;

  logic [31:0]     r_in_data;
  logic            r_in_last;
  logic            r_in_range;
  logic [31:0]     r_m_data, w_m_data_next;
  logic            r_m_last, w_m_last_next;
  logic [ChW-1:0]  r_clr_ch;
  logic [31:0]     r_in_cnt;
  logic [31:0]     r_out_cnt;

  logic [7:0]      w_s_ch, w_s_row, w_s_col;
  logic            w_s_in_range;
  logic            w_accept;
  logic            w_emit_hs;
  logic [IdxW-1:0] w_tas_idx;
  logic            w_was_set;
  logic            w_clr_en;
  logic            w_drop, w_merge;
  logic [7:0]      w_prow, w_pcol;

  // Range and bitmap index come straight from the incoming beat so the bitmap's
  // registered answer is ready in LOOKUP.
  assign w_s_ch       = s_axis_spike_tdata[CH_MSB:CH_LSB];
  assign w_s_row      = s_axis_spike_tdata[ROW_MSB:ROW_LSB];
  assign w_s_col      = s_axis_spike_tdata[COL_MSB:COL_LSB];
  assign w_s_in_range = (32'(w_s_ch) < CHANNELS) && (32'(w_s_row) < RowLimit) &&
                        (32'(w_s_col) < ColLimit);
  assign w_tas_idx    = IdxW'(((32'(w_s_ch) * OutHeight) + 32'(w_s_row >> PoolShift)) *
                              OutWidth + 32'(w_s_col >> PoolShift));

  assign s_axis_spike_tready = rst_n && enable && (r_state == StIdle);
  assign w_accept            = s_axis_spike_tready && s_axis_spike_tvalid;
  assign w_emit_hs           = (r_state == StEmit) && m_axis_spike_tready;
  assign w_clr_en            = (r_state == StClear);

  assign w_prow  = r_in_data[ROW_MSB:ROW_LSB] >> PoolShift;
  assign w_pcol  = r_in_data[COL_MSB:COL_LSB] >> PoolShift;
  assign w_drop  = (r_state == StLookup) && !r_in_range;
  assign w_merge = (r_state == StLookup) && r_in_range && w_was_set;

  snn_pool_bitmap #(
    .CHANNELS (CHANNELS),
    .MAP_BITS (MapBits),
    .IDX_W    (IdxW),
    .CH_W     (ChW)
  ) u_bitmap (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tas_en  (w_accept && w_s_in_range),
    .i_tas_idx (w_tas_idx),
    .o_was_set (w_was_set),
    .i_clr_en  (w_clr_en),
    .i_clr_ch  (r_clr_ch)
  );

  always_comb begin
    w_state_next  = r_state;
    w_m_data_next = r_m_data;
    w_m_last_next = r_m_last;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = StLookup;
      end
      StLookup: begin
        if (r_in_range && !w_was_set) begin
          w_state_next  = StEmit;
          w_m_data_next = {r_in_data[CH_MSB:CH_LSB], w_prow, w_pcol, r_in_data[TS_MSB:TS_LSB]};
          w_m_last_next = r_in_last;
        end else if (r_in_last) begin
          w_state_next  = StEmit;
          w_m_data_next = {SPIKE_MARKER_CH, 8'hFF, 8'hFF, r_in_data[TS_MSB:TS_LSB]};
          w_m_last_next = 1'b1;
        end else begin
          w_state_next = StIdle;
        end
      end
      StEmit: begin
        if (m_axis_spike_tready) w_state_next = r_m_last ? StClear : StIdle;
      end
      StClear: begin
        if (r_clr_ch == ChW'(CHANNELS - 1)) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_in_data  <= '0;
      r_in_last  <= 1'b0;
      r_in_range <= 1'b0;
      r_m_data   <= '0;
      r_m_last   <= 1'b0;
      r_clr_ch   <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_m_data <= w_m_data_next;
      r_m_last <= w_m_last_next;
      if (w_accept) begin
        r_in_data  <= s_axis_spike_tdata;
        r_in_last  <= s_axis_spike_tlast;
        r_in_range <= w_s_in_range;
        r_in_cnt   <= r_in_cnt + 32'd1;
      end
      if (w_emit_hs) r_out_cnt <= r_out_cnt + 32'd1;
      r_clr_ch <= w_clr_en ? r_clr_ch + ChW'(1) : '0;
    end
  end

`ifdef SNN_POOL_STATS_EN
  logic [31:0] r_drop_cnt, r_merge_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt  <= '0;
      r_merge_cnt <= '0;
    end else begin
      if (w_drop)  r_drop_cnt  <= r_drop_cnt + 32'd1;
      if (w_merge) r_merge_cnt <= r_merge_cnt + 32'd1;
    end
  end

  assign drop_count  = r_drop_cnt;
  assign merge_count = r_merge_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_drop ^ w_merge;
`endif

  assign m_axis_spike_tvalid = (r_state == StEmit);
  assign m_axis_spike_tdata  = r_m_data;
  assign m_axis_spike_tlast  = r_m_last;
  assign input_spike_count   = r_in_cnt;
  assign output_spike_count  = r_out_cnt;
  assign busy                = (r_state != StIdle);

endmodule

// File: tb/tb_snn_spike_pool2d.sv
// Self-checking bench for snn_spike_pool2d: vector table plus scoreboard of expected
// output beats, and hand sequences for stall, enable gating and mid-EMIT reset.
module tb_snn_spike_pool2d;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic [31:0] in_cnt, out_cnt;
  logic        busy;
`ifdef SNN_POOL_STATS_EN
  logic [31:0] drop_cnt, merge_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int exp_in = 0, exp_out = 0, exp_drop = 0, exp_merge = 0;

  typedef struct {
    logic [7:0]  ch, row, col, ts;
    logic        last;
    logic        emit;
    logic [31:0] exp_data;
    logic        exp_last;
    logic        drop;
    logic        merge;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];

  always #5 clk = ~clk;

  snn_spike_pool2d dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable              (enable),
    .s_axis_spike_tvalid (s_valid),
    .s_axis_spike_tdata  (s_data),
    .s_axis_spike_tlast  (s_last),
    .s_axis_spike_tready (s_ready),
    .m_axis_spike_tvalid (m_valid),
    .m_axis_spike_tdata  (m_data),
    .m_axis_spike_tlast  (m_last),
    .m_axis_spike_tready (m_ready),
    .input_spike_count   (in_cnt),
    .output_spike_count  (out_cnt),
    .busy                (busy)
`ifdef SNN_POOL_STATS_EN
    ,
    .drop_count          (drop_cnt),
    .merge_count         (merge_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output beats are compared at the falling edge before the accepting rising edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", m_data, 32'hxxxxxxxx);
      end else begin
        beat_t b;
        b = sb.pop_front();
        check("out_data", m_data, b.d);
        check("out_last", {31'd0, m_last}, {31'd0, b.l});
      end
    end
  end

  task automatic add_vec(input logic [7:0] ch, row, col, ts, input logic last, input logic emit,
                         input logic [31:0] exp_data, input logic exp_last,
                         input logic drop, input logic merge);
    vec_t v;
    v.ch = ch; v.row = row; v.col = col; v.ts = ts; v.last = last; v.emit = emit;
    v.exp_data = exp_data; v.exp_last = exp_last; v.drop = drop; v.merge = merge;
    vecs.push_back(v);
  endtask

  task automatic send(input logic [7:0] ch, row, col, ts, input logic last);
    int n = 0;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = {ch, row, col, ts};
    s_last  = last;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) check("send_timeout", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    exp_in++;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("idle_in_time", {31'd0, busy}, 32'd0);
  endtask

  task automatic push_exp(input logic [31:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    sb.push_back(b);
    exp_out++;
  endtask

  initial begin
    logic [31:0] held;
    logic        stable_ok;
    int          n;

    add_vec(8'd0, 8'd5, 8'd3, 8'd7, 1'b1, 1'b1, 32'h00020107, 1'b1, 1'b0, 1'b0);
    add_vec(8'd1, 8'd4, 8'd4, 8'd1, 1'b0, 1'b1, 32'h01020201, 1'b0, 1'b0, 1'b0);
    add_vec(8'd1, 8'd5, 8'd5, 8'd1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
    add_vec(8'd1, 8'd4, 8'd5, 8'd1, 1'b1, 1'b1, 32'hFFFFFF01, 1'b1, 1'b0, 1'b1);
    add_vec(8'd1, 8'd4, 8'd4, 8'd2, 1'b0, 1'b1, 32'h01020202, 1'b0, 1'b0, 1'b0);
    add_vec(8'd4, 8'd0, 8'd0, 8'd3, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0);
    add_vec(8'd0, 8'd8, 8'd0, 8'd3, 1'b1, 1'b1, 32'hFFFFFF03, 1'b1, 1'b1, 1'b0);
    add_vec(8'd3, 8'd7, 8'd7, 8'd9, 1'b1, 1'b1, 32'h03030309, 1'b1, 1'b0, 1'b0);
    add_vec(8'd2, 8'd0, 8'd8, 8'd4, 1'b1, 1'b1, 32'hFFFFFF04, 1'b1, 1'b1, 1'b0);

    // Reset state, with enable already high: tready must still be low.
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tready", {31'd0, s_ready}, 32'd0);
    check("rst_tvalid", {31'd0, m_valid}, 32'd0);
    check("rst_in_cnt", in_cnt, 32'd0);
    check("rst_out_cnt", out_cnt, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_tready", {31'd0, s_ready}, 32'd1);

    foreach (vecs[i]) begin
      if (vecs[i].emit) push_exp(vecs[i].exp_data, vecs[i].exp_last);
      if (vecs[i].drop) exp_drop++;
      if (vecs[i].merge) exp_merge++;
      send(vecs[i].ch, vecs[i].row, vecs[i].col, vecs[i].ts, vecs[i].last);
      wait_idle(7);
      check("sb_drained", sb.size(), 32'd0);
      check("in_cnt", in_cnt, exp_in);
      check("out_cnt", out_cnt, exp_out);
`ifdef SNN_POOL_STATS_EN
      check("drop_cnt", drop_cnt, exp_drop);
      check("merge_cnt", merge_cnt, exp_merge);
`endif
    end

    // Latency and stall: output appears at N+2 and holds while tready is low.
    m_ready = 1'b0;
    push_exp(32'h02000005, 1'b0);
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = 32'h02010105;
    s_last  = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    exp_in++;
    @(negedge clk);
    check("lookup_no_valid", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    check("valid_at_n2", {31'd0, m_valid}, 32'd1);
    held = m_data;
    stable_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_data !== held || !m_valid || s_ready || out_cnt !== exp_out - 1) stable_ok = 1'b0;
    end
    check("stall_stable", {31'd0, stable_ok}, 32'd1);
    check("stall_data", held, 32'h02000005);
    m_ready = 1'b1;
    wait_idle(10);
    check("stall_drained", sb.size(), 32'd0);
    check("stall_out_cnt", out_cnt, exp_out);

    // enable low: no beat is accepted.
    enable = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = 32'h03000001;
    stable_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (s_ready || busy) stable_ok = 1'b0;
    end
    check("enable_gates", {31'd0, stable_ok}, 32'd1);
    check("enable_in_cnt", in_cnt, exp_in);
    @(posedge clk); #1;
    s_valid = 1'b0;
    enable  = 1'b1;

    // Reset while in EMIT.
    m_ready = 1'b0;
    push_exp(32'h03000006, 1'b0);
    send(8'd3, 8'd0, 8'd0, 8'd6, 1'b0);
    n = 0;
    while (!m_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("emit_before_reset", {31'd0, m_valid}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_emit_tvalid", {31'd0, m_valid}, 32'd0);
    check("rst_emit_in_cnt", in_cnt, 32'd0);
    check("rst_emit_out_cnt", out_cnt, 32'd0);
    check("rst_emit_tready", {31'd0, s_ready}, 32'd0);
    sb.delete();
    exp_in = 0;
    exp_out = 0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    push_exp(32'h03000006, 1'b0);
    send(8'd3, 8'd0, 8'd0, 8'd6, 1'b0);
    wait_idle(10);
    check("post_rst_drained", sb.size(), 32'd0);
    check("post_rst_in_cnt", in_cnt, exp_in);
    check("post_rst_out_cnt", out_cnt, exp_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
